// File: rtl/mips_muldiv.sv
// Iterative MIPS HI/LO unit: 32-cycle shift-add multiply and restoring divide,
// plus MTHI/MTLO writes. Sign handling is done on magnitudes and fixed up at the end.
module mips_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic        bz_q, bz_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        sgn_op;
    logic [31:0] mag_a, mag_b;
    logic [32:0] trial;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        sgn_op   = (op == OP_MULT) || (op == OP_DIV);
        mag_a    = (sgn_op && a[31]) ? -a : a;
        mag_b    = (sgn_op && b[31]) ? -b : b;
        // Divide: acc_q[31:0] is the partial remainder, x_q[31:0] shifts dividend out / quotient in
        trial    = {acc_q[31:0], x_q[31]};
        prod_fix = neg_q  ? -acc_q       : acc_q;
        quo_fix  = neg_q  ? -x_q[31:0]   : x_q[31:0];
        rem_fix  = rneg_q ? -acc_q[31:0] : acc_q[31:0];

        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bz_d     = bz_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d  = RUN;
                            cnt_d    = 5'd31;
                            busy_d   = 1'b1;
                            is_div_d = op[1];
                            neg_d    = sgn_op & (a[31] ^ b[31]);
                            rneg_d   = sgn_op & a[31];
                            bz_d     = (b == 32'h0);
                            acc_d    = 64'h0;
                            x_d      = {32'h0, mag_a};
                            y_d      = mag_b;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (is_div_q) begin
                        if (trial >= {1'b0, y_q}) begin
                            acc_d = {32'h0, 32'(trial - {1'b0, y_q})};
                            x_d   = {x_q[62:0], 1'b1};
                        end else begin
                            acc_d = {32'h0, trial[31:0]};
                            x_d   = {x_q[62:0], 1'b0};
                        end
                    end else begin
                        acc_d = acc_q + (y_q[0] ? x_q : 64'h0);
                        x_d   = {x_q[62:0], 1'b0};
                        y_d   = {1'b0, y_q[31:1]};
                    end
                    if (cnt_q == 5'd0) state_d = FIX;
                    else               cnt_d   = cnt_q - 5'd1;
                end
            end
            FIX: begin
                state_d = abort ? IDLE : DONE;
                busy_d  = 1'b0;
                if (!abort) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // Zero divisor: remainder path already reconstructs a; only the quotient is forced
                        lo_d   = bz_q ? 32'hFFFF_FFFF : quo_fix;
                        hi_d   = rem_fix;
                        div0_d = bz_q;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bz_q     <= 1'b0;
            acc_q    <= 64'h0;
            x_q      <= 64'h0;
            y_q      <= 32'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bz_q     <= bz_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- op  in  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP.
- a  in  32  operand A (rs value, BusA of the datapath).
- b  in  32  operand B (rt value, BusB of the datapath).
- abort  in  1  synchronous cancel of an operation in progress.
- busy  out  1  high while an operation is in flight; the fetch unit stalls on it.
- done  out  1  one-cycle pulse when HI/LO receive a new mult/div result.
- div0  out  1  sticky flag: the last DIV/DIVU had b==0.
- hi  out  32  HI register (MFHI source).
- lo  out  32  LO register (MFLO source).

Function
REQ-002 The block SHALL use four states: IDLE, RUN, FIX and DONE.
REQ-003 In IDLE, start=1 with op MULT/MULTU/DIV/DIVU SHALL latch a, b and op, load the iteration counter with 31, and enter RUN.
REQ-004 In IDLE, start=1 with MTHI SHALL write hi<=a on that edge, and MTLO SHALL write lo<=a on that edge; neither sets busy or done.
REQ-005 In IDLE, start=1 with a NOP op SHALL have no effect.
REQ-006 Signed ops SHALL convert both operands to magnitudes at latch time, and SHALL record result signs:
- product/quotient sign = a[31]^b[31]
- remainder sign = a[31]
REQ-007 RUN SHALL perform exactly one iteration per cycle for 32 cycles:
- multiply: radix-2 shift-add into a 64-bit accumulator.
- divide: restoring, producing one quotient bit per cycle.
RUN SHALL decrement the counter each cycle and enter FIX when the counter equals 0.
REQ-008 FIX SHALL apply the two's-complement sign correction and write hi/lo in one cycle:
- MULT/MULTU: {hi,lo} = 64-bit product.
- DIV/DIVU: lo = quotient, hi = remainder.
FIX SHALL then enter DONE.
REQ-009 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-010 busy SHALL be high in RUN and FIX, and low in IDLE and DONE. With start at edge k, busy is high for 33 cycles and done is high in the cycle after edge k+33.
REQ-011 start asserted while busy=1 or in DONE SHALL be ignored; the datapath holds start until busy falls.
REQ-012 Division by zero (b==0) SHALL still take the full latency and SHALL produce lo=32'hFFFFFFFF and hi=a (original value). It SHALL set div0; a DIV/DIVU with b!=0 SHALL clear div0 at FIX.
REQ-013 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL produce lo=32'h80000000 and hi=0, with no trap.
REQ-014 abort=1 in RUN or FIX SHALL return the block to IDLE on the next edge with hi, lo and div0 unchanged and no done pulse. abort in IDLE or DONE SHALL be ignored.
REQ-015 If abort and start are both high in IDLE, start SHALL take effect.
REQ-016 hi and lo SHALL change only in FIX or on MTHI/MTLO. Operand changes on a/b after latch SHALL NOT affect the result.

Reset
REQ-017 reset=0 SHALL asynchronously force:
- state IDLE, counter 0
- busy=0, done=0, div0=0
- hi=32'h0, lo=32'h0
REQ-018 reset asserted mid-operation SHALL discard the operation, with no done pulse after release.
REQ-019 The first start SHALL be honoured on the first rising edge after reset deasserts.

Verification
REQ-020 MULT with a=32'hFFFFFFFE (-2), b=7 -> busy for 33 cycles, then done pulse; hi=32'hFFFFFFFF, lo=32'hFFFFFFF2.
REQ-021 MULTU with a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-022 DIV with a=-7 (32'hFFFFFFF9), b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). Then DIVU with a=100, b=0 -> lo=32'hFFFFFFFF, hi=100, div0=1.
REQ-023 MTHI a=32'h12345678 in IDLE -> hi updates next edge, busy stays 0. Start during busy -> ignored, and the in-flight result is unaffected.
REQ-024 MULT started, abort at RUN cycle 10 -> IDLE next edge, no done, hi/lo keep prior values. A new DIVU 9/4 then gives lo=2, hi=1.
REQ-025 reset pulsed low at RUN cycle 20 -> all outputs zero immediately, and no done after release.
